// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between riscv_mem_arbiter and its environment (IFU, LSU, memory).
// slave = the arbiter's view; master = the requesters and memory that surround it.
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_W-1:0]     ifu_req_addr;
  logic                  ifu_resp_valid;
  logic [DATA_W-1:0]     ifu_resp_data;
  logic                  ifu_resp_err;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_W-1:0]     lsu_req_addr;
  logic                  lsu_req_wen;
  logic [DATA_W-1:0]     lsu_req_wdata;
  logic [DATA_W/8-1:0]   lsu_req_wmask;
  logic                  lsu_resp_valid;
  logic [DATA_W-1:0]     lsu_resp_rdata;
  logic                  lsu_resp_err;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_req_addr;
  logic                  mem_req_wen;
  logic [DATA_W-1:0]     mem_req_wdata;
  logic [DATA_W/8-1:0]   mem_req_wmask;
  logic                  mem_resp_valid;
  logic [DATA_W-1:0]     mem_resp_rdata;

  logic                  busy;

  modport slave (
    input  ifu_req_valid, ifu_req_addr,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output busy
  );

  modport master (
    output ifu_req_valid, ifu_req_addr,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  busy
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Single-outstanding IFU/LSU arbiter onto one memory port, alternating grant on contention.
// Define ARB_TIMEOUT_EN to abort stalled transactions with an error response after TIMEOUT_CYC cycles.
module riscv_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  riscv_mem_arbiter_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state;
  logic                owner_lsu;
  logic                last_lsu;
  logic                grant_ifu;
  logic                grant_lsu;
  logic                complete;
  logic                abort;

  logic                mem_req_valid_q;
  logic [ADDR_W-1:0]   mem_req_addr_q;
  logic                mem_req_wen_q;
  logic [DATA_W-1:0]   mem_req_wdata_q;
  logic [MASK_W-1:0]   mem_req_wmask_q;

  logic                ifu_resp_valid_q;
  logic [DATA_W-1:0]   ifu_resp_data_q;
  logic                ifu_resp_err_q;
  logic                lsu_resp_valid_q;
  logic [DATA_W-1:0]   lsu_resp_rdata_q;
  logic                lsu_resp_err_q;

  // LSU wins contention only when IFU held the previous grant; grants are gated by reset.
  always_comb begin
    grant_lsu = rst_n && (state == IDLE) && bus.lsu_req_valid &&
                (!bus.ifu_req_valid || !last_lsu);
    grant_ifu = rst_n && (state == IDLE) && bus.ifu_req_valid && !grant_lsu;
    complete  = bus.mem_resp_valid &&
                (((state == REQ) && bus.mem_req_ready) || (state == RESP));
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;

  // Counter is zero in the first REQ cycle, so the abort fires on the TIMEOUT_CYC-th busy cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || (state == IDLE)) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign abort = (state != IDLE) && !complete && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign abort              = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      owner_lsu        <= 1'b0;
      last_lsu         <= 1'b0;
      mem_req_valid_q  <= 1'b0;
      mem_req_addr_q   <= '0;
      mem_req_wen_q    <= 1'b0;
      mem_req_wdata_q  <= '0;
      mem_req_wmask_q  <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_resp_data_q  <= '0;
      ifu_resp_err_q   <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      lsu_resp_rdata_q <= '0;
      lsu_resp_err_q   <= 1'b0;
    end else begin
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_lsu) begin
            mem_req_addr_q  <= bus.lsu_req_addr;
            mem_req_wen_q   <= bus.lsu_req_wen;
            mem_req_wdata_q <= bus.lsu_req_wdata;
            mem_req_wmask_q <= bus.lsu_req_wmask;
            mem_req_valid_q <= 1'b1;
            owner_lsu       <= 1'b1;
            last_lsu        <= 1'b1;
            state           <= REQ;
          end else if (grant_ifu) begin
            mem_req_addr_q  <= bus.ifu_req_addr;
            mem_req_wen_q   <= 1'b0;
            mem_req_wdata_q <= '0;
            mem_req_wmask_q <= '0;
            mem_req_valid_q <= 1'b1;
            owner_lsu       <= 1'b0;
            last_lsu        <= 1'b0;
            state           <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state           <= complete ? IDLE : RESP;
          end
        end
        RESP: begin
          if (complete) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // An abort never coincides with a completion, so it can override the case above.
      if (abort) begin
        mem_req_valid_q <= 1'b0;
        state           <= IDLE;
      end

      if (complete || abort) begin
        if (owner_lsu) begin
          lsu_resp_valid_q <= 1'b1;
          lsu_resp_rdata_q <= (abort || mem_req_wen_q) ? '0 : bus.mem_resp_rdata;
          lsu_resp_err_q   <= abort;
        end else begin
          ifu_resp_valid_q <= 1'b1;
          ifu_resp_data_q  <= abort ? '0 : bus.mem_resp_rdata;
          ifu_resp_err_q   <= abort;
        end
      end
    end
  end

  assign bus.ifu_req_ready  = grant_ifu;
  assign bus.lsu_req_ready  = grant_lsu;
  assign bus.mem_req_valid  = mem_req_valid_q;
  assign bus.mem_req_addr   = mem_req_addr_q;
  assign bus.mem_req_wen    = mem_req_wen_q;
  assign bus.mem_req_wdata  = mem_req_wdata_q;
  assign bus.mem_req_wmask  = mem_req_wmask_q;
  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.ifu_resp_data  = ifu_resp_data_q;
  assign bus.ifu_resp_err   = ifu_resp_err_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.lsu_resp_rdata = lsu_resp_rdata_q;
  assign bus.lsu_resp_err   = lsu_resp_err_q;
  assign bus.busy           = (state != IDLE);
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: response scoreboard plus cycle-level handshake checks.
module tb_riscv_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic        lsu;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_addr;
  logic        exp_wen;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_wmask;

  always #5 clk = ~clk;

  riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response scoreboard: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n === 1'b1 && (bus.ifu_resp_valid === 1'b1 || bus.lsu_resp_valid === 1'b1)) begin
      chk("resp_exclusive", bus.ifu_resp_valid & bus.lsu_resp_valid, 0);
      if (sb.size() == 0) begin
        chk("resp_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("resp_owner", bus.lsu_resp_valid, e.lsu);
        if (e.lsu) begin
          chk("lsu_resp_rdata", bus.lsu_resp_rdata, e.data);
          chk("lsu_resp_err", bus.lsu_resp_err, e.err);
        end else begin
          chk("ifu_resp_data", bus.ifu_resp_data, e.data);
          chk("ifu_resp_err", bus.ifu_resp_err, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_req_addr   = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_req_addr   = '0;
    bus.lsu_req_wen    = 1'b0;
    bus.lsu_req_wdata  = '0;
    bus.lsu_req_wmask  = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req_valid"}, bus.mem_req_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_ifu_resp_valid"}, bus.ifu_resp_valid, 0);
    chk({tag, "_lsu_resp_valid"}, bus.lsu_resp_valid, 0);
    chk({tag, "_ifu_resp_data"}, bus.ifu_resp_data, 0);
    chk({tag, "_lsu_resp_rdata"}, bus.lsu_resp_rdata, 0);
    chk({tag, "_resp_err"}, {bus.ifu_resp_err, bus.lsu_resp_err}, 0);
    chk({tag, "_mem_req_bus"}, {bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wmask}, 0);
    chk({tag, "_mem_req_wdata"}, bus.mem_req_wdata, 0);
  endtask

  // Called at the start of an IDLE cycle with the request inputs already driven.
  task automatic grant_step(input bit exp_lsu, input logic [31:0] rdata_plan,
                            input bit exp_err, input bit keep);
    exp_t e;
    #1;
    chk("ifu_req_ready", bus.ifu_req_ready, !exp_lsu);
    chk("lsu_req_ready", bus.lsu_req_ready, exp_lsu);
    if (exp_lsu) begin
      exp_addr  = bus.lsu_req_addr;
      exp_wen   = bus.lsu_req_wen;
      exp_wdata = bus.lsu_req_wdata;
      exp_wmask = bus.lsu_req_wmask;
    end else begin
      exp_addr  = bus.ifu_req_addr;
      exp_wen   = 1'b0;
      exp_wdata = '0;
      exp_wmask = '0;
    end
    e.lsu  = exp_lsu;
    e.err  = exp_err;
    e.data = (exp_err || (exp_lsu && exp_wen)) ? 32'h0 : rdata_plan;
    sb.push_back(e);
    step();
    if (!keep) begin
      if (exp_lsu) bus.lsu_req_valid = 1'b0;
      else         bus.ifu_req_valid = 1'b0;
    end
    chk("req_mem_req_valid", bus.mem_req_valid, 1);
    chk("req_busy", bus.busy, 1);
    chk("req_addr", bus.mem_req_addr, exp_addr);
    chk("req_wen", bus.mem_req_wen, exp_wen);
    chk("req_wdata", bus.mem_req_wdata, exp_wdata);
    chk("req_wmask", bus.mem_req_wmask, exp_wmask);
  endtask

  // Called in the first REQ cycle; returns in the IDLE cycle that carries the response pulse.
  task automatic mem_serve(input int ready_wait, input int resp_wait, input logic [31:0] rdata);
    #1;
    chk("no_grant_while_busy", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
    bus.mem_resp_rdata = rdata;
    for (int i = 0; i < ready_wait; i++) begin
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = (i == 0);
      step();
      bus.mem_resp_valid = 1'b0;
      chk("hold_valid", bus.mem_req_valid, 1);
      chk("hold_addr", bus.mem_req_addr, exp_addr);
      chk("hold_wdata", bus.mem_req_wdata, exp_wdata);
      chk("hold_wmask", bus.mem_req_wmask, exp_wmask);
      chk("hold_busy", bus.busy, 1);
      chk("hold_no_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    end
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = (resp_wait == 0);
    step();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    if (resp_wait > 0) begin
      chk("resp_wait_req_dropped", bus.mem_req_valid, 0);
      for (int i = 1; i < resp_wait; i++) step();
      chk("resp_wait_busy", bus.busy, 1);
      chk("resp_wait_no_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
      bus.mem_resp_valid = 1'b1;
      step();
      bus.mem_resp_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    step();
    do_reset();
    chk_all_zero("reset");
    chk("reset_no_grant", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);

    // IFU alone, zero-wait memory: ready in N, mem_req_valid in N+1, pulse in N+2.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h8000_0000;
    grant_step(1'b0, 32'h0000_0413, 1'b0, 1'b0);
    mem_serve(0, 0, 32'h0000_0413);
    chk("t1_ifu_pulse", bus.ifu_resp_valid, 1);
    chk("t1_ifu_data", bus.ifu_resp_data, 32'h0000_0413);
    chk("t1_lsu_quiet", bus.lsu_resp_valid, 0);
    chk("t1_idle", bus.busy, 0);
    step();
    chk("t1_pulse_single", bus.ifu_resp_valid, 0);
    chk("t1_data_held", bus.ifu_resp_data, 32'h0000_0413);

    // Contention straight after reset: LSU store first, then IFU.
    do_reset();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h8000_0004;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 32'h8000_0100;
    bus.lsu_req_wen   = 1'b1;
    bus.lsu_req_wdata = 32'hDEAD_BEEF;
    bus.lsu_req_wmask = 4'hF;
    grant_step(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    mem_serve(0, 0, 32'h1234_5678);
    chk("t2_lsu_pulse", bus.lsu_resp_valid, 1);
    chk("t2_store_rdata", bus.lsu_resp_rdata, 0);
    grant_step(1'b0, 32'h0000_0013, 1'b0, 1'b0);
    mem_serve(0, 0, 32'h0000_0013);

    // Both held valid: grants alternate LSU, IFU, LSU, IFU.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h8000_0008;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 32'h8000_0200;
    bus.lsu_req_wen   = 1'b0;
    bus.lsu_req_wdata = 32'h0;
    bus.lsu_req_wmask = 4'h0;
    for (int k = 0; k < 4; k++) begin
      grant_step((k % 2) == 0, 32'hA000_0000 + k, 1'b0, 1'b1);
      mem_serve(0, 0, 32'hA000_0000 + k);
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    step();
    chk("t3_idle_after", bus.busy, 0);

    // Memory stalls ready for 5 cycles; request registers must hold despite input churn.
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 32'h8000_0300;
    bus.lsu_req_wen   = 1'b1;
    bus.lsu_req_wdata = 32'hCAFE_F00D;
    bus.lsu_req_wmask = 4'h3;
    grant_step(1'b1, 32'h0000_0055, 1'b0, 1'b0);
    bus.lsu_req_addr  = 32'h0;
    bus.lsu_req_wdata = 32'h0;
    bus.lsu_req_wmask = 4'h0;
    mem_serve(5, 2, 32'h0000_0055);
    chk("t4_lsu_pulse", bus.lsu_resp_valid, 1);
    chk("t4_store_rdata", bus.lsu_resp_rdata, 0);

    // LSU load through the RESP state returns memory data.
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 32'h8000_0400;
    bus.lsu_req_wen   = 1'b0;
    grant_step(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
    mem_serve(0, 1, 32'h0BAD_F00D);
    chk("t4b_load_rdata", bus.lsu_resp_rdata, 32'h0BAD_F00D);

    // Reset while waiting in RESP; a late memory response must be ignored.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h8000_0010;
    grant_step(1'b0, 32'h0000_0099, 1'b0, 1'b0);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk("t5_in_resp", {bus.busy, bus.mem_req_valid}, 2'b10);
    rst_n = 1'b0;
    sb.delete();
    step();
    rst_n = 1'b1;
    chk_all_zero("t5_reset");
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h7777_7777;
    step();
    bus.mem_resp_valid = 1'b0;
    chk_all_zero("t5_late_resp");
    step();
    chk("t5_still_quiet", {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.busy}, 0);

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: error pulse after 8 busy cycles, then back to IDLE.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h8000_0020;
    grant_step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("t6_waiting_valid", bus.mem_req_valid, 1);
      chk("t6_waiting_no_resp", bus.ifu_resp_valid, 0);
    end
    step();
    chk("t6_err_pulse", bus.ifu_resp_valid, 1);
    chk("t6_err", bus.ifu_resp_err, 1);
    chk("t6_err_data", bus.ifu_resp_data, 0);
    chk("t6_req_dropped", bus.mem_req_valid, 0);
    chk("t6_idle", bus.busy, 0);
    bus.mem_resp_valid = 1'b1;
    step();
    bus.mem_resp_valid = 1'b0;
    chk("t6_late_ignored", {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.busy}, 0);
`endif

    step();
    step();
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
